// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings, field widths and helpers for the I2C arbiter and master
package i2c_pkg;

    localparam int SADDR_W = 7;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_XFER  = 3'd3,
        ST_RESP  = 3'd4
    } arb_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

    // Round-robin pointer advance: one past the last winner, wrapping at n-1.
    function automatic int rr_next(input int win, input int n);
        return (win >= n - 1) ? 0 : win + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after the pointer
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_valid && i_req[(int'(i_ptr) + i) % N_REQ]) begin
                o_valid                               = 1'b1;
                o_gnt[(int'(i_ptr) + i) % N_REQ]      = 1'b1;
                o_idx                                 = IDX_W'((int'(i_ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin sharing of one I2C master among N_REQ requesters
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_rw,
    input  logic [SADDR_W*N_REQ-1:0] req_saddr,
    input  logic [BYTE_W*N_REQ-1:0]  req_raddr,
    input  logic [BYTE_W*N_REQ-1:0]  req_wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [BYTE_W-1:0]        rdata,
    output logic                     err,
    output logic                     m_start,
    output logic                     m_rw,
    output logic [SADDR_W-1:0]       m_saddr,
    output logic [BYTE_W-1:0]        m_raddr,
    output logic [BYTE_W-1:0]        m_wdata,
    input  logic                     m_busy,
    input  logic                     m_done,
    input  logic [BYTE_W-1:0]        m_rdata,
    input  logic                     m_nack
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    arb_state_t          r_state;
    arb_state_t          w_next_state;

    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_win;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_done;
    logic [BYTE_W-1:0]   r_rdata;
    err_code_t           r_err_code;
    logic                r_m_start;
    logic                r_m_rw;
    logic [SADDR_W-1:0]  r_m_saddr;
    logic [BYTE_W-1:0]   r_m_raddr;
    logic [BYTE_W-1:0]   r_m_wdata;
    logic [WD_W-1:0]     r_wd;

    logic                r_busy_s1;
    logic                r_busy_s2;
    logic                r_done_s1;
    logic                r_done_s2;
    logic                r_done_s3;

    logic [N_REQ-1:0]    w_arb_gnt;
    logic [PTR_W-1:0]    w_arb_idx;
    logic                w_arb_valid;
    logic                w_done_rise;
    logic                w_wd_expire;
    logic                w_to_resp;
    err_code_t           w_resp_code;
    logic [BYTE_W-1:0]   w_resp_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (PTR_W)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // The master runs on its own clock; busy and done are resynchronised here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_s1 <= 1'b0;
            r_busy_s2 <= 1'b0;
            r_done_s1 <= 1'b0;
            r_done_s2 <= 1'b0;
            r_done_s3 <= 1'b0;
        end else begin
            r_busy_s1 <= m_busy;
            r_busy_s2 <= r_busy_s1;
            r_done_s1 <= m_done;
            r_done_s2 <= r_done_s1;
            r_done_s3 <= r_done_s2;
        end
    end

    assign w_done_rise = r_done_s2 & ~r_done_s3;
    assign w_wd_expire = (r_wd == WD_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_to_resp    = 1'b0;
        w_resp_code  = ERR_NONE;
        w_resp_data  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_next_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_next_state = ST_START;
            end
            ST_START: begin
                if (r_busy_s2) begin
                    w_next_state = ST_XFER;
                end else if (w_wd_expire) begin
                    w_next_state = ST_RESP;
                    w_to_resp    = 1'b1;
                    w_resp_code  = ERR_TIMEOUT;
                end
            end
            ST_XFER: begin
                if (w_done_rise) begin
                    w_next_state = ST_RESP;
                    w_to_resp    = 1'b1;
                    w_resp_code  = m_nack ? ERR_NACK : ERR_NONE;
                    w_resp_data  = r_m_rw ? m_rdata : '0;
                end else if (w_wd_expire) begin
                    w_next_state = ST_RESP;
                    w_to_resp    = 1'b1;
                    w_resp_code  = ERR_TIMEOUT;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Restarts on every state change so START and XFER each get a full budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (w_next_state != r_state) begin
            r_wd <= '0;
        end else if (!w_wd_expire) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_win      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_err_code <= ERR_NONE;
            r_m_start  <= 1'b0;
            r_m_rw     <= 1'b0;
            r_m_saddr  <= '0;
            r_m_raddr  <= '0;
            r_m_wdata  <= '0;
        end else begin
            r_done <= '0;
            if (r_state == ST_IDLE && w_arb_valid) begin
                r_win <= w_arb_idx;
                r_gnt <= w_arb_gnt;
            end
            if (r_state == ST_GRANT) begin
                r_m_rw    <= req_rw[r_win];
                r_m_saddr <= req_saddr[int'(r_win)*SADDR_W +: SADDR_W];
                r_m_raddr <= req_raddr[int'(r_win)*BYTE_W +: BYTE_W];
                r_m_wdata <= req_wdata[int'(r_win)*BYTE_W +: BYTE_W];
                r_m_start <= 1'b1;
            end
            if (r_state == ST_START && w_next_state != ST_START) begin
                r_m_start <= 1'b0;
            end
            if (w_to_resp) begin
                r_done     <= r_gnt;
                r_rdata    <= w_resp_data;
                r_err_code <= w_resp_code;
            end
            if (r_state == ST_RESP) begin
                r_gnt <= '0;
                r_ptr <= PTR_W'(rr_next(int'(r_win), N_REQ));
            end
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign rdata   = r_rdata;
    assign err     = (r_err_code != ERR_NONE);
    assign m_start = r_m_start;
    assign m_rw    = r_m_rw;
    assign m_saddr = r_m_saddr;
    assign m_raddr = r_m_raddr;
    assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - directed self-checking bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   req_rw;
    logic [7*N-1:0] req_saddr;
    logic [8*N-1:0] req_raddr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [7:0]     rdata;
    logic           err;
    logic           m_start;
    logic           m_rw;
    logic [6:0]     m_saddr;
    logic [7:0]     m_raddr;
    logic [7:0]     m_wdata;
    logic           m_busy;
    logic           m_done;
    logic [7:0]     m_rdata;
    logic           m_nack;

    logic [6:0]     tb_sa [N];
    logic [7:0]     tb_ra [N];
    logic [7:0]     tb_wd [N];
    logic           tb_rw [N];

    int n_checks;
    int n_errors;

    i2c_txn_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rw    (req_rw),
        .req_saddr (req_saddr),
        .req_raddr (req_raddr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .m_start   (m_start),
        .m_rw      (m_rw),
        .m_saddr   (m_saddr),
        .m_raddr   (m_raddr),
        .m_wdata   (m_wdata),
        .m_busy    (m_busy),
        .m_done    (m_done),
        .m_rdata   (m_rdata),
        .m_nack    (m_nack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int i, input logic rw, input logic [6:0] sa,
                              input logic [7:0] ra, input logic [7:0] wd);
        tb_rw[i] = rw;
        tb_sa[i] = sa;
        tb_ra[i] = ra;
        tb_wd[i] = wd;
        req_rw[i]          = rw;
        req_saddr[i*7 +: 7] = sa;
        req_raddr[i*8 +: 8] = ra;
        req_wdata[i*8 +: 8] = wd;
    endtask

    task automatic wait_gnt(input int exp_win);
        logic [N-1:0] exp_gnt;
        int waited;
        exp_gnt          = '0;
        exp_gnt[exp_win] = 1'b1;
        waited           = 0;
        while (gnt == '0 && waited < 20) begin
            step();
            waited++;
        end
        check("gnt", gnt, exp_gnt);
    endtask

    // Plays the master side of one transaction and checks the cycle-exact handshake.
    task automatic serve(input int exp_win, input logic [7:0] rd_byte, input logic nack, input logic drop);
        logic [N-1:0] exp_gnt;
        logic [7:0]   exp_rd;
        exp_gnt          = '0;
        exp_gnt[exp_win] = 1'b1;
        exp_rd           = tb_rw[exp_win] ? rd_byte : 8'h00;
        wait_gnt(exp_win);
        step();
        check("m_start_on", m_start, 1);
        check("m_rw", m_rw, tb_rw[exp_win]);
        check("m_saddr", m_saddr, tb_sa[exp_win]);
        check("m_raddr", m_raddr, tb_ra[exp_win]);
        check("m_wdata", m_wdata, tb_wd[exp_win]);
        req_rw[exp_win]           = ~tb_rw[exp_win];
        req_saddr[exp_win*7 +: 7] = ~tb_sa[exp_win];
        req_wdata[exp_win*8 +: 8] = ~tb_wd[exp_win];
        m_busy = 1'b1;
        repeat (2) step();
        check("m_start_hold", m_start, 1);
        step();
        check("m_start_drop", m_start, 0);
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_rdata = rd_byte;
        m_nack  = nack;
        step();
        m_done = 1'b0;
        step();
        check("done_early", done, 0);
        step();
        check("done", done, exp_gnt);
        check("rdata", rdata, exp_rd);
        check("err", err, nack);
        check("m_saddr_hold", m_saddr, tb_sa[exp_win]);
        check("m_wdata_hold", m_wdata, tb_wd[exp_win]);
        check("gnt_thru_done", gnt, exp_gnt);
        set_fields(exp_win, tb_rw[exp_win], tb_sa[exp_win], tb_ra[exp_win], tb_wd[exp_win]);
        if (drop) req[exp_win] = 1'b0;
        step();
        check("done_one_cycle", done, 0);
        check("gnt_clear", gnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [N-1:0] seen_done;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req       = '0;
        req_rw    = '0;
        req_saddr = '0;
        req_raddr = '0;
        req_wdata = '0;
        m_busy    = 1'b0;
        m_done    = 1'b0;
        m_rdata   = 8'h00;
        m_nack    = 1'b0;
        set_fields(0, 1'b1, 7'h48, 8'h00, 8'h11);
        set_fields(1, 1'b0, 7'h50, 8'h10, 8'hA5);
        set_fields(2, 1'b1, 7'h51, 8'h22, 8'h22);
        set_fields(3, 1'b0, 7'h68, 8'h33, 8'h5C);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("rst_m_start", m_start, 0);
        check("rst_m_fields", {m_rw, m_saddr, m_raddr, m_wdata}, 0);

        step();
        req[1] = 1'b1;
        serve(1, 8'hEE, 1'b0, 1'b1);

        req[2] = 1'b1;
        serve(2, 8'h3C, 1'b0, 1'b1);

        req[3] = 1'b1;
        wait_gnt(3);
        step();
        m_busy = 1'b1;
        repeat (3) step();
        check("xfer_m_start_low", m_start, 0);
        rst = 1'b1;
        #1;
        check("arst_gnt", gnt, 0);
        check("arst_m_start", m_start, 0);
        check("arst_m_saddr", m_saddr, 0);
        m_busy = 1'b0;
        req    = '0;
        step();
        rst       = 1'b0;
        seen_done = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen_done = seen_done | done;
        end
        check("no_done_after_rst", seen_done, 0);

        req = 4'b1111;
        serve(0, 8'h01, 1'b0, 1'b0);
        serve(1, 8'h02, 1'b0, 1'b0);
        serve(2, 8'h03, 1'b0, 1'b0);
        serve(3, 8'h04, 1'b0, 1'b0);
        serve(0, 8'h05, 1'b0, 1'b0);
        req = '0;

        req[3] = 1'b1;
        serve(3, 8'h00, 1'b1, 1'b1);
        req[0] = 1'b1;
        serve(0, 8'h5A, 1'b0, 1'b1);

        req[1] = 1'b1;
        wait_gnt(1);
        step();
        check("to_m_start_on", m_start, 1);
        repeat (15) step();
        check("to_m_start_late", m_start, 1);
        check("to_done_early", done, 0);
        step();
        check("to_done", done, 4'b0010);
        check("to_err", err, 1);
        check("to_rdata", rdata, 0);
        check("to_m_start_off", m_start, 0);
        req[1] = 1'b0;
        step();
        check("to_gnt_clear", gnt, 0);
        check("to_m_start_stays_low", m_start, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
